// File: rtl/rom_ahb_ctrl.sv
// rom_ahb_ctrl: AHB-Lite read-only slave driving a synchronous ROM macro
module rom_ahb_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              n_hreset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic              hready_in,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              rom_cen,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);
  localparam int BOFF = (DATA_W == 64) ? 3 : 2;
  localparam logic [3:0] WLOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic [DATA_W-1:0] rdata_q;
  logic cap;
  logic open_st, accept, err_size, misalign, err, good;
  logic [2:0] mask;
  // accept qualification and error classification; WAIT/ERR1 never accept
  always_comb begin
    open_st  = (state == IDLE) || (state == DATA) || (state == ERR2);
    accept   = hsel & htrans[1] & hready_in & open_st;
    mask     = 3'((4'd1 << hsize[1:0]) - 4'd1);
    err_size = hsize > 3'(BOFF);
    misalign = !err_size && (|(haddr[2:0] & mask));
    err      = hwrite | err_size | misalign;
    good     = accept & ~err;
  end
  // ROM strobe is combinational from the address phase, held off in reset
  always_comb begin
    rom_cen  = ~(good & n_hreset);
    rom_addr = haddr[ADDR_W+BOFF-1:BOFF];
  end
  // bus responses decode purely from state
  always_comb begin
    hready = open_st;
    hresp  = {1'b0, (state == ERR1) || (state == ERR2)};
    hrdata = (WAIT_STATES == 0) ? rom_dout : rdata_q;
  end
  // next state and wait counter
  always_comb begin
    state_nx = good ? ((WAIT_STATES == 0) ? DATA : WAIT) : (accept ? ERR1 : IDLE);
    wcnt_nx  = good ? WLOAD : wcnt;
    if (state == WAIT) begin
      state_nx = (wcnt == 4'd0) ? DATA : WAIT;
      wcnt_nx  = (wcnt == 4'd0) ? wcnt : wcnt - 4'd1;
    end
    if (state == ERR1) begin
      state_nx = ERR2;
      wcnt_nx  = wcnt;
    end
  end
  // state, counter and read-data capture registers
  always_ff @(posedge hclk) begin
    if (!n_hreset) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      rdata_q <= '0;
      cap     <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      cap     <= good;
      rdata_q <= cap ? rom_dout : rdata_q;
    end
  end
endmodule
